// File: rtl/bsg_nonsynth_dramsim3_ch_router.sv
// Channel router for DRAMSim3 channel models.
//
// Takes one request stream (v_i/ready_o) carrying global byte addresses,
// decodes the channel index according to address_mapping_p, strips the
// channel bits out of the address and buffers each request in a per-channel
// FIFO. Per-channel read responses are merged back into a single stream by a
// round-robin arbiter feeding a one-entry output register.
//
// Ports:
//   clk_i, reset_n_i         clock, asynchronous active-low reset
//   v_i .. mask_i, ready_o   incoming request (accepted on v_i & ready_o)
//   ch_*_o, ch_yumi_i        per-channel request heads, consumed by ch_yumi_i
//   ch_resp_*                per-channel read responses, taken by ch_resp_yumi_o
//   resp_*                   merged response stream, consumed by resp_yumi_i
//
// address_mapping_p encodings:
//   0 = e_ro_ra_bg_ba_co_ch, 1 = e_ro_ra_bg_ba_ch_co, 2 = e_ro_ch_ra_ba_bg_co
module bsg_nonsynth_dramsim3_ch_router #(
  parameter int unsigned channel_addr_width_p = 16,
  parameter int unsigned data_width_p         = 32,
  parameter int unsigned num_channels_p       = 1,
  parameter int unsigned num_columns_p        = 1024,
  parameter int unsigned num_rows_p           = 1024,
  parameter int unsigned num_ba_p             = 4,
  parameter int unsigned num_bg_p             = 4,
  parameter int unsigned num_ranks_p          = 1,
  parameter int unsigned address_mapping_p    = 0,
  parameter int unsigned fifo_els_p           = 2,
  parameter int unsigned debug_p              = 0,
  localparam int unsigned lg_ch_lp      = (num_channels_p > 1) ? $clog2(num_channels_p) : 1,
  localparam int unsigned addr_width_lp = $clog2(num_channels_p) + channel_addr_width_p,
  localparam int unsigned mask_width_lp = data_width_p >> 3
) (
  input  logic                                         clk_i,
  input  logic                                         reset_n_i,

  input  logic                                         v_i,
  input  logic                                         write_not_read_i,
  input  logic [addr_width_lp-1:0]                     addr_i,
  input  logic [data_width_p-1:0]                      data_i,
  input  logic [mask_width_lp-1:0]                     mask_i,
  output logic                                         ready_o,

  output logic [num_channels_p-1:0]                    ch_v_o,
  output logic [num_channels_p-1:0]                    ch_write_not_read_o,
  output logic [num_channels_p*channel_addr_width_p-1:0] ch_addr_o,
  output logic [num_channels_p*data_width_p-1:0]       ch_data_o,
  output logic [num_channels_p*mask_width_lp-1:0]      ch_mask_o,
  input  logic [num_channels_p-1:0]                    ch_yumi_i,

  input  logic [num_channels_p-1:0]                    ch_resp_v_i,
  input  logic [num_channels_p*data_width_p-1:0]       ch_resp_data_i,
  output logic [num_channels_p-1:0]                    ch_resp_yumi_o,

  output logic                                         resp_v_o,
  output logic [data_width_p-1:0]                      resp_data_o,
  output logic [lg_ch_lp-1:0]                          resp_ch_o,
  input  logic                                         resp_yumi_i
);

  localparam int unsigned e_ro_ra_bg_ba_co_ch = 0;
  localparam int unsigned e_ro_ra_bg_ba_ch_co = 1;

  localparam int unsigned ch_bits_lp = $clog2(num_channels_p);
  localparam int unsigned bo_lp      = (mask_width_lp > 1) ? $clog2(mask_width_lp) : 1;
  localparam int unsigned lg_co_lp   = $clog2(num_columns_p);
  localparam int unsigned lg_bg_lp   = $clog2(num_bg_p);
  localparam int unsigned lg_ba_lp   = $clog2(num_ba_p);
  localparam int unsigned lg_ra_lp   = $clog2(num_ranks_p);

  // Bit position of the lowest channel bit in the global address.
  localparam int unsigned ch_pos_lp =
      (address_mapping_p == e_ro_ra_bg_ba_co_ch) ? bo_lp :
      (address_mapping_p == e_ro_ra_bg_ba_ch_co) ? bo_lp + lg_co_lp :
      bo_lp + lg_co_lp + lg_bg_lp + lg_ba_lp + lg_ra_lp;

  localparam int unsigned entry_w_lp = 1 + channel_addr_width_p + data_width_p + mask_width_lp;
  localparam int unsigned ptr_w_lp   = $clog2(fifo_els_p);
  localparam int unsigned cnt_w_lp   = $clog2(fifo_els_p + 1);

  // Channel-local address: channel bits squeezed out, byte offset zeroed.
  function automatic logic [channel_addr_width_p-1:0] unmap(input logic [addr_width_lp-1:0] a);
    logic [channel_addr_width_p-1:0] r;
    r = '0;
    for (int i = 0; i < int'(channel_addr_width_p); i++) begin
      if (i < int'(bo_lp))          r[i] = 1'b0;
      else if (i < int'(ch_pos_lp)) r[i] = a[i];
      else                          r[i] = a[i + int'(ch_bits_lp)];
    end
    return r;
  endfunction

  // ---------------- request path ----------------
  logic [lg_ch_lp-1:0]       req_ch;
  logic [entry_w_lp-1:0]     wr_entry;
  logic [num_channels_p-1:0] full, empty;

  if (num_channels_p == 1) begin : g_one_ch
    assign req_ch = '0;
  end else begin : g_multi_ch
    assign req_ch = lg_ch_lp'(addr_i >> ch_pos_lp);
  end

  assign wr_entry = {write_not_read_i, unmap(addr_i), data_i, mask_i};
  // No credit for a same-cycle dequeue: a full FIFO always stalls.
  assign ready_o  = ~full[req_ch];

  for (genvar c = 0; c < int'(num_channels_p); c++) begin : g_fifo
    logic [entry_w_lp-1:0] mem_q [fifo_els_p];
    logic [ptr_w_lp-1:0]   rd_q, wr_q;
    logic [cnt_w_lp-1:0]   cnt_q;
    logic                  enq, deq;

    assign full[c]  = (cnt_q == cnt_w_lp'(fifo_els_p));
    assign empty[c] = (cnt_q == '0);
    assign enq      = v_i & ~full[c] & (req_ch == lg_ch_lp'(c));
    assign deq      = ch_yumi_i[c] & ~empty[c];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (enq) wr_q <= (wr_q == ptr_w_lp'(fifo_els_p - 1)) ? '0 : wr_q + 1'b1;
        if (deq) rd_q <= (rd_q == ptr_w_lp'(fifo_els_p - 1)) ? '0 : rd_q + 1'b1;
        if (enq && !deq)      cnt_q <= cnt_q + 1'b1;
        else if (!enq && deq) cnt_q <= cnt_q - 1'b1;
      end
    end

    // Storage needs no reset; the occupancy count alone defines validity.
    always_ff @(posedge clk_i) begin
      if (enq) mem_q[wr_q] <= wr_entry;
    end

    assign ch_v_o[c] = ~empty[c];
    assign {ch_write_not_read_o[c],
            ch_addr_o[c*channel_addr_width_p +: channel_addr_width_p],
            ch_data_o[c*data_width_p +: data_width_p],
            ch_mask_o[c*mask_width_lp +: mask_width_lp]} = mem_q[rd_q];
  end

  // ---------------- response path ----------------
  logic                    resp_v_q;
  logic [data_width_p-1:0] resp_data_q;
  logic [lg_ch_lp-1:0]     resp_ch_q, ptr_q, ptr_next, gnt;
  logic                    found, load_en, do_grant;

  assign load_en  = ~resp_v_q | resp_yumi_i;
  assign do_grant = load_en & found;

  // First requesting channel at or after the priority pointer, wrapping.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    gnt   = '0;
    for (int unsigned i = 0; i < num_channels_p; i++) begin
      idx = (int'(ptr_q) + i) % num_channels_p;
      if (!found && ch_resp_v_i[idx]) begin
        found = 1'b1;
        gnt   = lg_ch_lp'(idx);
      end
    end
  end

  assign ptr_next = (gnt == lg_ch_lp'(num_channels_p - 1)) ? '0 : gnt + 1'b1;

  always_comb begin
    ch_resp_yumi_o = '0;
    if (do_grant && reset_n_i) ch_resp_yumi_o[gnt] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_v_q    <= 1'b0;
      resp_data_q <= '0;
      resp_ch_q   <= '0;
      ptr_q       <= '0;
    end else if (load_en) begin
      resp_v_q <= found;
      if (found) begin
        resp_data_q <= ch_resp_data_i[gnt*data_width_p +: data_width_p];
        resp_ch_q   <= gnt;
        ptr_q       <= ptr_next;
      end
    end
  end

  assign resp_v_o    = resp_v_q;
  assign resp_data_o = resp_data_q;
  assign resp_ch_o   = resp_ch_q;

`ifndef SYNTHESIS
  yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (ch_yumi_i & ~ch_v_o) == '0)
    else $error("ch_router: ch_yumi_i=%b while ch_v_o=%b", ch_yumi_i, ch_v_o);

  always_ff @(posedge clk_i) begin
    if (debug_p != 0 && reset_n_i) begin
      if (v_i && ready_o)
        $display("ch_router: enq ch=%0d we=%b addr=%h", req_ch, write_not_read_i, addr_i);
      if (do_grant)
        $display("ch_router: resp grant ch=%0d", gnt);
    end
  end
`endif

endmodule

// File: tb/tb_bsg_nonsynth_dramsim3_ch_router.sv
module tb_bsg_nonsynth_dramsim3_ch_router;

  // Main instance: 4 channels, 32-bit data, co_ch mapping -> ch = addr[3:2].
  localparam int unsigned CaW = 10;
  localparam int unsigned DW  = 32;
  localparam int unsigned NCH = 4;
  localparam int unsigned MW  = 4;
  localparam int unsigned AW  = 12;

  logic             clk, rst_n;
  logic             v, wnr, ready;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    wdata;
  logic [MW-1:0]    mask;
  logic [NCH-1:0]   ch_v, ch_wnr, ch_yumi, ch_resp_v, ch_resp_yumi;
  logic [NCH*CaW-1:0] ch_addr;
  logic [NCH*DW-1:0]  ch_data, ch_resp_data;
  logic [NCH*MW-1:0]  ch_mask;
  logic             resp_v, resp_yumi;
  logic [DW-1:0]    resp_data;
  logic [1:0]       resp_ch;

  // Second instance: 2 channels for the literal decode vectors.
  logic         v2, wnr2, ready2, resp_v2, resp_yumi2;
  logic [10:0]  addr2;
  logic [31:0]  wdata2, resp_data2;
  logic [3:0]   mask2;
  logic [1:0]   ch_v2, ch_wnr2, ch_yumi2, ch_resp_v2, ch_resp_yumi2;
  logic [19:0]  ch_addr2;
  logic [63:0]  ch_data2, ch_resp_data2;
  logic [7:0]   ch_mask2;
  logic [0:0]   resp_ch2;

  bsg_nonsynth_dramsim3_ch_router #(
    .channel_addr_width_p(CaW), .data_width_p(DW), .num_channels_p(NCH),
    .num_columns_p(16), .num_rows_p(64), .num_ba_p(4), .num_bg_p(2), .num_ranks_p(1),
    .address_mapping_p(0), .fifo_els_p(2), .debug_p(0)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .v_i(v), .write_not_read_i(wnr), .addr_i(addr), .data_i(wdata), .mask_i(mask),
    .ready_o(ready),
    .ch_v_o(ch_v), .ch_write_not_read_o(ch_wnr), .ch_addr_o(ch_addr), .ch_data_o(ch_data),
    .ch_mask_o(ch_mask), .ch_yumi_i(ch_yumi),
    .ch_resp_v_i(ch_resp_v), .ch_resp_data_i(ch_resp_data), .ch_resp_yumi_o(ch_resp_yumi),
    .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_ch_o(resp_ch), .resp_yumi_i(resp_yumi)
  );

  bsg_nonsynth_dramsim3_ch_router #(
    .channel_addr_width_p(10), .data_width_p(32), .num_channels_p(2),
    .num_columns_p(16), .num_rows_p(64), .num_ba_p(4), .num_bg_p(2), .num_ranks_p(1),
    .address_mapping_p(0), .fifo_els_p(2), .debug_p(0)
  ) dut2 (
    .clk_i(clk), .reset_n_i(rst_n),
    .v_i(v2), .write_not_read_i(wnr2), .addr_i(addr2), .data_i(wdata2), .mask_i(mask2),
    .ready_o(ready2),
    .ch_v_o(ch_v2), .ch_write_not_read_o(ch_wnr2), .ch_addr_o(ch_addr2), .ch_data_o(ch_data2),
    .ch_mask_o(ch_mask2), .ch_yumi_i(ch_yumi2),
    .ch_resp_v_i(ch_resp_v2), .ch_resp_data_i(ch_resp_data2), .ch_resp_yumi_o(ch_resp_yumi2),
    .resp_v_o(resp_v2), .resp_data_o(resp_data2), .resp_ch_o(resp_ch2), .resp_yumi_i(resp_yumi2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic        wnr;
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  m;
  } req_t;

  req_t        sb[$];
  int unsigned rsp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference decode for the 4-channel instance.
  function automatic req_t model_req(input logic [11:0] a, input logic w,
                                     input logic [31:0] d, input logic [3:0] m);
    req_t r;
    r.ch  = a[3:2];
    r.wnr = w;
    r.a   = 10'((a >> 4) << 2);
    r.d   = d;
    r.m   = m;
    return r;
  endfunction

  // Called at a negedge; returns at the next negedge with v dropped.
  task automatic send(input logic [11:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] m);
    v = 1'b1; addr = a; wnr = w; wdata = d; mask = m;
    #1;
    check_eq("send_ready", ready, 1'b1);
    if (ready) sb.push_back(model_req(a, w, d, m));
    @(negedge clk);
    v = 1'b0;
  endtask

  // Compare the head of channel c with the oldest expected entry for c, then consume it.
  task automatic pop(input int c);
    req_t e;
    int   idx = -1;
    e = '0;
    check_eq("pop_valid", ch_v[c], 1'b1);
    for (int i = 0; i < sb.size(); i++)
      if (idx < 0 && sb[i].ch == 2'(c)) idx = i;
    check_eq("pop_sb_hit", idx >= 0, 1'b1);
    if (idx >= 0) begin
      e = sb[idx];
      sb.delete(idx);
    end
    check_eq("pop_head", {ch_wnr[c], ch_addr[c*10 +: 10], ch_data[c*32 +: 32], ch_mask[c*4 +: 4]},
             {e.wnr, e.a, e.d, e.m});
    ch_yumi[c] = 1'b1;
    @(negedge clk);
    ch_yumi[c] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned c;
    rst_n = 1'b0;
    v = 1'b1; wnr = 1'b1; addr = 12'h104; wdata = '0; mask = '0;
    ch_yumi = '0; ch_resp_v = '0; ch_resp_data = '0; resp_yumi = 1'b0;
    v2 = 1'b0; wnr2 = 1'b0; addr2 = '0; wdata2 = '0; mask2 = '0;
    ch_yumi2 = '0; ch_resp_v2 = '0; ch_resp_data2 = '0; resp_yumi2 = 1'b0;

    // Reset held with v_i high: nothing enters, outputs at reset values.
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_ready", ready, 1'b1);
      check_eq("rst_ch_v", ch_v, 4'h0);
      check_eq("rst_resp", {resp_v, resp_ch, resp_data}, '0);
    end
    v = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ch_v", ch_v, 4'h0);
    check_eq("post_rst_resp_v", resp_v, 1'b0);

    // Literal decode vectors on the 2-channel instance.
    v2 = 1'b1; addr2 = 11'h104; wnr2 = 1'b1; wdata2 = 32'hCAFE_0001; mask2 = 4'hF;
    #1 check_eq("dec0_ready", ready2, 1'b1);
    @(negedge clk); v2 = 1'b0;
    check_eq("dec0_ch_v", ch_v2, 2'b10);
    check_eq("dec0_ch_addr", ch_addr2[19:10], 10'h080);
    check_eq("dec0_data", ch_data2[63:32], 32'hCAFE_0001);
    ch_yumi2 = 2'b10;
    @(negedge clk); ch_yumi2 = 2'b00;
    v2 = 1'b1; addr2 = 11'h108; wnr2 = 1'b0; wdata2 = 32'hCAFE_0002; mask2 = 4'h5;
    @(negedge clk); v2 = 1'b0;
    check_eq("dec1_ch_v", ch_v2, 2'b01);
    check_eq("dec1_ch_addr", ch_addr2[9:0], 10'h084);
    check_eq("dec1_fields", {ch_wnr2[0], ch_mask2[3:0]}, 5'b0_0101);
    ch_yumi2 = 2'b01;
    @(negedge clk); ch_yumi2 = 2'b00;
    check_eq("dec_drained", ch_v2, 2'b00);

    // Backpressure on ch0 with depth 2.
    send(12'h010, 1'b1, 32'h1111_0000, 4'hF);
    check_eq("lat1_ch_v", ch_v[0], 1'b1);
    send(12'h020, 1'b0, 32'h2222_0000, 4'h3);
    v = 1'b1; addr = 12'h030; wnr = 1'b1; wdata = 32'h3333_0000; mask = 4'hC;
    #1 check_eq("bp_full_ready", ready, 1'b0);
    pop(0);  // dequeue while full: enqueue must still stall this cycle
    #1 check_eq("bp_next_ready", ready, 1'b1);
    if (ready) sb.push_back(model_req(12'h030, 1'b1, 32'h3333_0000, 4'hC));
    @(negedge clk); v = 1'b0;
    pop(0);
    pop(0);
    check_eq("bp_empty", ch_v[0], 1'b0);

    // Independent channels drained out of arrival order.
    send(12'h014, 1'b1, $urandom, 4'h1);
    send(12'h028, 1'b0, $urandom, 4'h2);
    send(12'h03C, 1'b1, $urandom, 4'h4);
    send(12'h054, 1'b0, $urandom, 4'h8);
    check_eq("multi_ch_v", ch_v, 4'b1110);
    pop(3);
    pop(2);
    pop(1);
    pop(1);
    check_eq("multi_empty", ch_v, 4'h0);

    // Enqueue and dequeue together on a non-full channel.
    send(12'h018, 1'b1, 32'hAAAA_0001, 4'hF);
    v = 1'b1; addr = 12'h0A8; wnr = 1'b0; wdata = 32'hAAAA_0002; mask = 4'h6;
    #1 check_eq("simul_ready", ready, 1'b1);
    if (ready) sb.push_back(model_req(12'h0A8, 1'b0, 32'hAAAA_0002, 4'h6));
    pop(2);
    v = 1'b0;
    pop(2);
    check_eq("simul_empty", ch_v[2], 1'b0);

    // Round-robin arbitration with all channels requesting.
    for (int k = 0; k < 4; k++) ch_resp_data[k*32 +: 32] = 32'hD000_0000 + k;
    ch_resp_v = 4'hF; resp_yumi = 1'b1;
    rsp_q = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      #1 check_eq("arb_gnt", ch_resp_yumi, 4'b1 << rsp_q[0]);
      @(negedge clk);
      c = rsp_q.pop_front();
      check_eq("arb_v", resp_v, 1'b1);
      check_eq("arb_ch", resp_ch, c);
      check_eq("arb_data", resp_data, 32'hD000_0000 + c);
    end
    ch_resp_v = 4'h0;
    @(negedge clk);
    check_eq("arb_drain", resp_v, 1'b0);

    // Output register full and not consumed: others must wait.
    resp_yumi = 1'b0; ch_resp_v = 4'b0100;
    #1 check_eq("hold_gnt2", ch_resp_yumi, 4'b0100);
    @(negedge clk);
    ch_resp_v = 4'b1000;
    #1 check_eq("hold_no_gnt", ch_resp_yumi, 4'b0000);
    @(negedge clk);
    check_eq("hold_ch", {resp_v, resp_ch}, 3'b1_10);
    resp_yumi = 1'b1;
    #1 check_eq("hold_gnt3", ch_resp_yumi, 4'b1000);
    @(negedge clk);
    ch_resp_v = 4'h0;
    check_eq("hold_resp3", {resp_ch, resp_data}, {2'd3, 32'hD000_0003});
    @(negedge clk);
    resp_yumi = 1'b0;
    check_eq("hold_drain", resp_v, 1'b0);

    // Mid-traffic asynchronous reset.
    send(12'h010, 1'b1, 32'h5555_0000, 4'hF);
    send(12'h014, 1'b1, 32'h6666_0000, 4'hF);
    ch_resp_v = 4'b0001;
    @(negedge clk);
    ch_resp_v = 4'b0010;
    check_eq("mid_pre_ch_v", ch_v, 4'b0011);
    check_eq("mid_pre_resp_v", resp_v, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_ch_v", ch_v, 4'h0);
    check_eq("mid_resp", {resp_v, resp_ch, resp_data}, '0);
    check_eq("mid_resp_yumi", ch_resp_yumi, 4'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    ch_resp_v = 4'h0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_post_ch_v", ch_v, 4'h0);
    check_eq("mid_post_resp_v", resp_v, 1'b0);
    send(12'h024, 1'b0, 32'h7777_0000, 4'h9);
    check_eq("mid_fresh_ch_v", ch_v, 4'b0010);
    pop(1);
    check_eq("mid_final_empty", ch_v, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
